// File: rtl/pht_update_ctrl.sv
// pht_upd_fifo: generic FIFO with a synchronous flush and an occupancy count.
// Latency: an entry pushed at edge E is visible at the head right after E.
// Backpressure: push_rdy is low only when full; a flush wins over a push.
// Ports: push_vld/push_rdy/push_dat (write side), pop_vld/pop_rdy/pop_dat (head),
//        flush (drop all entries), count (entries held).
module pht_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_vld,
  output logic                     push_rdy,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     pop_vld,
  input  logic                     pop_rdy,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_fire, pop_fire;

  assign push_rdy  = (cnt_q != CW'(DEPTH));
  assign pop_vld   = (cnt_q != '0);
  assign pop_dat   = mem_q[rd_ptr_q];
  assign count     = cnt_q;
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_rdy && pop_vld;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives
  // the modulo wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_fire && !pop_fire) cnt_d = cnt_q + 1'b1;
      else if (!push_fire && pop_fire) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: only slots below the count are ever read.
  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// pht_update_ctrl: PHT write-port scheduler -- init sweep, then saturating-counter RMW of queued updates.
// Latency: update accepted at edge E is written (registered) after E+1, committed to the PHT at E+2.
// Backpressure: upd_ready = !full of the update queue; queue fills (not drained) while sweeping.
// Ports: upd_valid/upd_index/upd_taken/upd_ready (M-stage updates), clear_req (re-init),
//        pht_rd_index/pht_rd_data (comb read of queue head), pht_we/pht_wr_index/pht_wr_data
//        (registered write port), busy (sweep in progress), pending (queue occupancy).
module pht_update_ctrl #(
  parameter int         PHT_DEPTH  = 6,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_STATE = 2'b10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          upd_valid,
  input  logic [PHT_DEPTH-1:0]          upd_index,
  input  logic                          upd_taken,
  output logic                          upd_ready,
  input  logic                          clear_req,
  output logic [PHT_DEPTH-1:0]          pht_rd_index,
  input  logic [1:0]                    pht_rd_data,
  output logic                          pht_we,
  output logic [PHT_DEPTH-1:0]          pht_wr_index,
  output logic [1:0]                    pht_wr_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);
  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [PHT_DEPTH-1:0] idx;
    logic                 taken;
  } upd_t;

  localparam logic [PHT_DEPTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [PHT_DEPTH-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [PHT_DEPTH-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]           wr_dat_q, wr_dat_d;
  logic                 busy_q, busy_d;

  upd_t                 push_dat, head;
  logic                 head_vld, pop, flush;
  logic                 fwd;
  logic [1:0]           cur, nxt;

  assign push_dat = '{idx: upd_index, taken: upd_taken};

  pht_upd_fifo #(
    .WIDTH ($bits(upd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push_vld (upd_valid),
    .push_rdy (upd_ready),
    .push_dat (push_dat),
    .pop_vld  (head_vld),
    .pop_rdy  (pop),
    .pop_dat  (head),
    .count    (pending)
  );

  assign pht_rd_index = head.idx;

  // The write register holds a value the PHT has not yet absorbed, so a
  // back-to-back update to the same index must read it instead of the array.
  assign fwd = we_q && (wr_idx_q == head.idx);
  assign cur = fwd ? wr_dat_q : pht_rd_data;

  always_comb begin
    nxt = cur;
    if (head.taken) begin
      if (cur != 2'b11) nxt = cur + 2'd1;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    wr_idx_d = wr_idx_q;
    wr_dat_d = wr_dat_q;
    pop      = 1'b0;
    flush    = 1'b0;
    case (state_q)
      SWEEP: begin
        we_d     = 1'b1;
        wr_idx_d = cnt_q;
        wr_dat_d = INIT_STATE;
        cnt_d    = cnt_q + 1'b1;
        // A clear mid-sweep simply restarts the count; queued updates survive.
        if (clear_req)             cnt_d   = '0;
        else if (cnt_q == CNT_MAX) state_d = RUN;
      end
      RUN: begin
        if (clear_req) begin
          // Drop the queue (including this cycle's head and any push).
          state_d = SWEEP;
          cnt_d   = '0;
          flush   = 1'b1;
        end else if (head_vld) begin
          pop      = 1'b1;
          we_d     = 1'b1;
          wr_idx_d = head.idx;
          wr_dat_d = nxt;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  // busy rises with entry into SWEEP and falls one edge after leaving it,
  // i.e. once the final sweep write has committed.
  assign busy_d = (state_d == SWEEP) || (state_q == SWEEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SWEEP;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wr_idx_q <= '0;
      wr_dat_q <= 2'b00;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wr_idx_q <= wr_idx_d;
      wr_dat_q <= wr_dat_d;
      busy_q   <= busy_d;
    end
  end

  assign pht_we       = we_q;
  assign pht_wr_index = wr_idx_q;
  assign pht_wr_data  = wr_dat_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_pht_update_ctrl.sv
module tb_pht_update_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       upd_valid = 1'b0;
  logic [5:0] upd_index = '0;
  logic       upd_taken = 1'b0;
  logic       upd_ready;
  logic       clear_req = 1'b0;
  logic [5:0] pht_rd_index;
  logic [1:0] pht_rd_data;
  logic       pht_we;
  logic [5:0] pht_wr_index;
  logic [1:0] pht_wr_data;
  logic       busy;
  logic [2:0] pending;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [5:0] idx;
    logic [1:0] dat;
  } wr_t;

  wr_t        exp_q[$];
  logic [1:0] model[64];
  logic [1:0] pht_mem[64];
  int         run_len = 0;
  int         last_run = 0;

  always #5 clk = ~clk;

  pht_update_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .upd_valid    (upd_valid),
    .upd_index    (upd_index),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .clear_req    (clear_req),
    .pht_rd_index (pht_rd_index),
    .pht_rd_data  (pht_rd_data),
    .pht_we       (pht_we),
    .pht_wr_index (pht_wr_index),
    .pht_wr_data  (pht_wr_data),
    .busy         (busy),
    .pending      (pending)
  );

  // PHT storage stand-in: combinational read, write commits at the edge.
  assign pht_rd_data = pht_mem[pht_rd_index];
  always @(posedge clk) if (pht_we) pht_mem[pht_wr_index] <= pht_wr_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
    else   return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  // Scoreboard: every presented write must match the oldest expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst && pht_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", {31'd0, pht_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_idx", {26'd0, pht_wr_index}, {26'd0, e.idx});
        check("wr_dat", {30'd0, pht_wr_data}, {30'd0, e.dat});
      end
    end
    if (pht_we) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic load_sweep();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      model[i] = 2'b10;
      exp_q.push_back('{idx: 6'(i), dat: 2'b10});
    end
  endtask

  // Called at a negedge; checks reset values without any clock edge.
  task automatic do_reset();
    rst = 1'b0;
    upd_valid = 1'b0;
    clear_req = 1'b0;
    #1;
    check("rst_we",    {31'd0, pht_we}, 32'd0);
    check("rst_idx",   {26'd0, pht_wr_index}, 32'd0);
    check("rst_dat",   {30'd0, pht_wr_data}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd1);
    check("rst_pend",  {29'd0, pending}, 32'd0);
    check("rst_ready", {31'd0, upd_ready}, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    load_sweep();
  endtask

  // Drive one update for one cycle; starts and ends just after a posedge.
  task automatic send(input logic [5:0] idx, input logic tk, output bit acc);
    logic [1:0] v;
    upd_valid = 1'b1;
    upd_index = idx;
    upd_taken = tk;
    @(negedge clk);
    acc = upd_ready;
    if (acc) begin
      v = sat(model[idx], tk);
      model[idx] = v;
      exp_q.push_back('{idx: idx, dat: v});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input logic [5:0] idx, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (pht_we && pht_wr_index == idx) found = 1'b1;
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_sweep_done(input string tag);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit acc;
    int occ;
    for (int i = 0; i < 64; i++) pht_mem[i] = 2'b00;

    // 1: reset and full init sweep
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("t1_we",    {31'd0, pht_we}, 32'd1);
      check("t1_busy",  {31'd0, busy}, 32'd1);
      check("t1_ready", {31'd0, upd_ready}, 32'd1);
    end
    @(negedge clk);
    check("t1_busy_fall", {31'd0, busy}, 32'd0);
    check("t1_we_fall",   {31'd0, pht_we}, 32'd0);
    @(negedge clk);
    check("t1_run_len", last_run, 32'd64);

    // 2: single update latency
    @(posedge clk); #1;
    send(6'd5, 1'b1, acc);
    check("t2_acc", {31'd0, acc}, 32'd1);
    check("t2_pend1", {29'd0, pending}, 32'd1);
    upd_valid = 1'b0;
    @(posedge clk); #1;
    check("t2_pend0", {29'd0, pending}, 32'd0);
    check("t2_we",    {31'd0, pht_we}, 32'd1);
    check("t2_idx",   {26'd0, pht_wr_index}, 32'd5);
    check("t2_dat",   {30'd0, pht_wr_data}, 32'd3);
    repeat (3) @(posedge clk); #1;

    // 3: back-to-back same index, forwarding and saturation
    for (int i = 0; i < 6; i++) begin
      send(6'd7, (i < 3), acc);
      check("t3_acc", {31'd0, acc}, 32'd1);
    end
    upd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_model_end", {30'd0, model[7]}, 32'd0);

    // 4: fill the queue during a sweep
    @(negedge clk);
    do_reset();
    @(posedge clk); #1;
    occ = 0;
    for (int i = 0; i < 5; i++) begin
      send(6'(10 + i), i[0], acc);
      check("t4_ready", {31'd0, acc}, {31'd0, (occ < 4)});
      if (acc) occ++;
    end
    upd_valid = 1'b0;
    check("t4_pend", {29'd0, pending}, 32'd4);
    wait_sweep_done("t4_sweep_done");
    repeat (6) @(negedge clk);
    check("t4_run_len", last_run, 32'd68);
    check("t4_pend_end", {29'd0, pending}, 32'd0);

    // 5: clear_req in RUN with three queued updates
    @(negedge clk);
    do_reset();
    @(posedge clk); #1;
    send(6'd20, 1'b1, acc);
    send(6'd21, 1'b0, acc);
    send(6'd22, 1'b1, acc);
    upd_valid = 1'b0;
    wait_wr(6'd63, "t5_reach_63");
    check("t5_pend3", {29'd0, pending}, 32'd3);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("t5_pend0", {29'd0, pending}, 32'd0);
    check("t5_busy",  {31'd0, busy}, 32'd1);
    check("t5_we",    {31'd0, pht_we}, 32'd0);
    load_sweep();
    wait_sweep_done("t5_sweep_done");
    repeat (4) @(negedge clk);
    check("t5_run_len", last_run, 32'd64);

    // 6: reset mid-sweep
    @(negedge clk);
    do_reset();
    @(posedge clk); #1;
    send(6'd40, 1'b1, acc);
    upd_valid = 1'b0;
    wait_wr(6'd30, "t6_reach_30");
    check("t6_pend_pre", {29'd0, pending}, 32'd1);
    do_reset();
    @(negedge clk);
    check("t6_restart_we",  {31'd0, pht_we}, 32'd1);
    check("t6_restart_idx", {26'd0, pht_wr_index}, 32'd0);
    wait_sweep_done("t6_sweep_done");
    repeat (4) @(negedge clk);
    check("t6_run_len", last_run, 32'd64);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
